// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU column-window feeder.
package fpu_pkg;

    localparam int FPU_MAC_LAT   = 5;
    localparam int FPU_COL_WIDTH = 10;

    typedef logic [7:0] pixel_t;
    typedef pixel_t column_t [FPU_COL_WIDTH];

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        STREAM,
        DRAIN,
        PAD
    } win_state_t;

endpackage

// File: rtl/fpu_col_window_tag.sv
// fpu_tag_delay: MAC_LAT-deep {valid,last} shift register that tracks windows through the MAC.
module fpu_tag_delay #(
    parameter int MAC_LAT = fpu_pkg::FPU_MAC_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last
);

    logic [MAC_LAT-1:0] v_sr;
    logic [MAC_LAT-1:0] l_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sr <= '0;
            l_sr <= '0;
        end else begin
            v_sr[0] <= in_valid;
            l_sr[0] <= in_last;
            for (int i = 1; i < MAC_LAT; i++) begin
                v_sr[i] <= v_sr[i-1];
                l_sr[i] <= l_sr[i-1];
            end
        end
    end

    assign out_valid = v_sr[MAC_LAT-1];
    assign out_last  = l_sr[MAC_LAT-1];

endmodule

// File: rtl/fpu_col_window.sv
// Three-column sliding window feeder for the FPU 3x3 MAC, with result tags aligned to MAC latency.
// Optional FPU_WIN_EDGE_REPLICATE_EN: edge-replicated padding, N windows per stripe, N >= 2.
//
// state  | meaning
// IDLE   | waiting for start; cfg_num_cols checked here
// FILL   | accepting the first two columns, no window yet (edge mode: first window on 2nd)
// STREAM | each accepted column emits one window
// PAD    | edge mode only: one extra shift with col2 held for the right border
// DRAIN  | no input; waits for the last tag to leave the delay line
module fpu_col_window
    import fpu_pkg::*;
#(
    parameter int COL_WIDTH = FPU_COL_WIDTH,
    parameter int MAC_LAT   = FPU_MAC_LAT,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_num_cols,
    input  logic             in_valid,
    output logic             in_ready,
    input  pixel_t           in_col [COL_WIDTH-1:0],
    output pixel_t           col0   [COL_WIDTH-1:0],
    output pixel_t           col1   [COL_WIDTH-1:0],
    output pixel_t           col2   [COL_WIDTH-1:0],
    output logic             win_valid,
    output logic             res_valid,
    output logic             res_last,
    output logic             busy,
    output logic             cfg_err
);

`ifdef FPU_WIN_EDGE_REPLICATE_EN
    localparam bit               EDGE_EN = 1'b1;
    localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(2);
`else
    localparam bit               EDGE_EN = 1'b0;
    localparam logic [CNT_W-1:0] MIN_N   = CNT_W'(3);
`endif

    win_state_t       state, state_nxt;
    logic [CNT_W-1:0] col_cnt;
    logic [CNT_W-1:0] num_cols;
    logic [CNT_W-1:0] cnt_nxt;
    logic             xfer;
    logic             last_col;
    logic             start_ok;
    logic             win_last;
    logic             win_valid_nxt;
    logic             win_last_nxt;

    assign in_ready = (state == FILL) || (state == STREAM);
    assign busy     = (state != IDLE);
    assign xfer     = in_valid && in_ready;
    assign cnt_nxt  = col_cnt + CNT_W'(1);
    assign last_col = xfer && (cnt_nxt == num_cols);
    assign start_ok = (state == IDLE) && start && (cfg_num_cols >= MIN_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        // First window appears once MIN_N columns are in, in both modes.
        win_valid_nxt = (xfer && (cnt_nxt >= MIN_N)) || (state == PAD);
        win_last_nxt  = EDGE_EN ? (state == PAD) : last_col;
        case (state)
            IDLE:    if (start_ok) state_nxt = FILL;
            FILL: begin
                if (last_col)                          state_nxt = EDGE_EN ? PAD : DRAIN;
                else if (xfer && (cnt_nxt == CNT_W'(2))) state_nxt = STREAM;
            end
            STREAM:  if (last_col) state_nxt = EDGE_EN ? PAD : DRAIN;
            PAD:     state_nxt = DRAIN;
            DRAIN:   if (res_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt   <= '0;
            num_cols  <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < COL_WIDTH; i++) begin
                col0[i] <= '0;
                col1[i] <= '0;
                col2[i] <= '0;
            end
        end else begin
            win_valid <= win_valid_nxt;
            win_last  <= win_last_nxt;
            cfg_err   <= (state == IDLE) && start && (cfg_num_cols < MIN_N);
            if (start_ok) begin
                num_cols <= cfg_num_cols;
                col_cnt  <= '0;
            end
            if (xfer) begin
                col_cnt <= cnt_nxt;
                // Edge mode replicates the first column into the whole window.
                if (EDGE_EN && (col_cnt == '0)) begin
                    col0 <= in_col;
                    col1 <= in_col;
                    col2 <= in_col;
                end else begin
                    col0 <= col1;
                    col1 <= col2;
                    col2 <= in_col;
                end
            end else if (state == PAD) begin
                col0 <= col1;
                col1 <= col2;
            end
        end
    end

    fpu_tag_delay #(
        .MAC_LAT (MAC_LAT)
    ) u_tag_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (win_valid),
        .in_last   (win_last),
        .out_valid (res_valid),
        .out_last  (res_last)
    );

endmodule

// File: tb/tb_fpu_col_window.sv
// Directed testbench for fpu_col_window (default build and FPU_WIN_EDGE_REPLICATE_EN build).
`timescale 1ns/1ps
module tb_fpu_col_window;
    import fpu_pkg::*;

    localparam int CW  = 10;
    localparam int LAT = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] cfg_num_cols = '0;
    logic        in_ready, win_valid, res_valid, res_last, busy, cfg_err;
    pixel_t      in_col [CW-1:0];
    pixel_t      col0 [CW-1:0];
    pixel_t      col1 [CW-1:0];
    pixel_t      col2 [CW-1:0];

    int checks = 0;
    int failures = 0;

    int win_cyc[$];
    int w0[$];
    int w1[$];
    int w2[$];
    bit wuni[$];
    int res_cyc[$];
    bit res_lst[$];
    int busy_fall, ready_drop, held_viol;
    bit timed_out;

    always #5 clk = ~clk;

    fpu_col_window #(.COL_WIDTH(CW), .MAC_LAT(LAT), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_cols(cfg_num_cols),
        .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
        .col0(col0), .col1(col1), .col2(col2),
        .win_valid(win_valid), .res_valid(res_valid), .res_last(res_last),
        .busy(busy), .cfg_err(cfg_err)
    );

    // Drives one stripe and logs windows/results; checks are done by the callers.
    task automatic run_stripe(input int n, input bit gaps, input int base, input bit drain_start);
        int k, cyc, p0, p1, p2;
        bit ph, seen, uni;
        win_cyc.delete(); w0.delete(); w1.delete(); w2.delete(); wuni.delete();
        res_cyc.delete(); res_lst.delete();
        busy_fall = -1; ready_drop = -1; held_viol = 0; timed_out = 1'b0;
        k = 0; cyc = 0; ph = 1'b1; seen = 1'b0; p0 = 0; p1 = 0; p2 = 0;
        @(negedge clk); start = 1'b1; cfg_num_cols = 16'(n);
        @(negedge clk); start = 1'b0;
        forever begin
            cyc++;
            if (win_valid) begin
                uni = 1'b1;
                for (int i = 0; i < CW; i++)
                    if (col0[i] != col0[0] || col1[i] != col1[0] || col2[i] != col2[0]) uni = 1'b0;
                win_cyc.push_back(cyc); w0.push_back(int'(col0[0]));
                w1.push_back(int'(col1[0])); w2.push_back(int'(col2[0])); wuni.push_back(uni);
                seen = 1'b1;
            end else if (seen && (int'(col0[0]) != p0 || int'(col1[0]) != p1 || int'(col2[0]) != p2)) begin
                held_viol++;
            end
            p0 = int'(col0[0]); p1 = int'(col1[0]); p2 = int'(col2[0]);
            if (res_valid) begin
                res_cyc.push_back(cyc); res_lst.push_back(res_last);
            end
            if (!in_ready && busy && ready_drop < 0) ready_drop = cyc;
            if (!busy) begin
                busy_fall = cyc; start = 1'b0; in_valid = 1'b0;
                break;
            end
            if (cyc > 300) begin
                timed_out = 1'b1; start = 1'b0; in_valid = 1'b0;
                break;
            end
            start = drain_start && (k == n) && !in_ready;
            if (k < n && (!gaps || ph)) begin
                in_valid = 1'b1;
                for (int i = 0; i < CW; i++) in_col[i] = pixel_t'(base + k + 1);
                if (in_ready) k++;
            end else begin
                in_valid = 1'b0;
            end
            ph = !ph;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int rv, nz;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({win_valid, res_valid, res_last, busy, cfg_err, in_ready} !== 6'b0) begin
            failures++; $display("FAIL reset_init got=%b exp=000000", {win_valid, res_valid, res_last, busy, cfg_err, in_ready});
        end
        rst_n = 1'b1;
        @(negedge clk); start = 1'b1; cfg_num_cols = 16'd8;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            for (int i = 0; i < CW; i++) in_col[i] = pixel_t'(k + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL reset_midstripe_busy got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        nz = 0;
        for (int i = 0; i < CW; i++) if (col0[i] != 0 || col1[i] != 0 || col2[i] != 0) nz++;
        checks++;
        if ({win_valid, res_valid, res_last, busy, cfg_err, in_ready} !== 6'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=000000", {win_valid, res_valid, res_last, busy, cfg_err, in_ready});
        end
        checks++;
        if (nz != 0) begin failures++; $display("FAIL reset_window nonzero_pixels=%0d exp=0", nz); end
        @(negedge clk); rst_n = 1'b1;
        rv = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid || busy || in_ready) rv++;
        end
        checks++;
        if (rv != 0) begin failures++; $display("FAIL reset_no_res_after got=%0d cycles_active exp=0", rv); end
    endtask

    task automatic test_basic;
        run_stripe(5, 1'b0, 0, 1'b0);
        checks++;
        if (timed_out) begin failures++; $display("FAIL basic_timeout got=1 exp=0"); end
        checks++;
        if (win_cyc.size() != 3) begin failures++; $display("FAIL basic_win_count got=%0d exp=3", win_cyc.size()); end
        for (int i = 0; i < win_cyc.size(); i++) begin
            checks++;
            if (w0[i] != i + 1 || w1[i] != i + 2 || w2[i] != i + 3 || !wuni[i]) begin
                failures++; $display("FAIL basic_window%0d got={%0d,%0d,%0d} uni=%0d exp={%0d,%0d,%0d} uni=1",
                                     i, w0[i], w1[i], w2[i], wuni[i], i + 1, i + 2, i + 3);
            end
        end
        checks++;
        if (res_cyc.size() != 3) begin failures++; $display("FAIL basic_res_count got=%0d exp=3", res_cyc.size()); end
        for (int i = 0; i < res_cyc.size() && i < win_cyc.size(); i++) begin
            checks++;
            if (res_cyc[i] - win_cyc[i] != LAT || res_lst[i] != (i == 2)) begin
                failures++; $display("FAIL basic_res%0d got=lat%0d last%0d exp=lat%0d last%0d",
                                     i, res_cyc[i] - win_cyc[i], res_lst[i], LAT, (i == 2));
            end
        end
        if (res_cyc.size() == 3) begin
            checks++;
            if (busy_fall != res_cyc[2] + 1) begin
                failures++; $display("FAIL basic_busy_fall got=%0d exp=%0d", busy_fall, res_cyc[2] + 1);
            end
        end
    endtask

    task automatic test_bubbles;
        run_stripe(6, 1'b1, 0, 1'b0);
        checks++;
        if (timed_out || win_cyc.size() != 4) begin
            failures++; $display("FAIL bubbles_win_count got=%0d timeout=%0d exp=4", win_cyc.size(), timed_out);
        end
        for (int i = 0; i < win_cyc.size(); i++) begin
            checks++;
            if (w0[i] != i + 1 || w1[i] != i + 2 || w2[i] != i + 3) begin
                failures++; $display("FAIL bubbles_window%0d got={%0d,%0d,%0d} exp={%0d,%0d,%0d}",
                                     i, w0[i], w1[i], w2[i], i + 1, i + 2, i + 3);
            end
        end
        for (int i = 1; i < win_cyc.size(); i++) begin
            checks++;
            if (win_cyc[i] - win_cyc[i-1] != 2) begin
                failures++; $display("FAIL bubbles_win_spacing%0d got=%0d exp=2", i, win_cyc[i] - win_cyc[i-1]);
            end
        end
        checks++;
        if (held_viol != 0) begin failures++; $display("FAIL bubbles_hold got=%0d changes exp=0", held_viol); end
        checks++;
        if (res_cyc.size() != win_cyc.size()) begin
            failures++; $display("FAIL bubbles_res_count got=%0d exp=%0d", res_cyc.size(), win_cyc.size());
        end
        for (int i = 0; i < res_cyc.size() && i < win_cyc.size(); i++) begin
            checks++;
            if (res_cyc[i] - win_cyc[i] != LAT) begin
                failures++; $display("FAIL bubbles_res_lat%0d got=%0d exp=%0d", i, res_cyc[i] - win_cyc[i], LAT);
            end
        end
    endtask

    task automatic test_illegal;
        int n_bad, n_min, exp_w;
`ifdef FPU_WIN_EDGE_REPLICATE_EN
        n_bad = 1; n_min = 2; exp_w = 2;
`else
        n_bad = 2; n_min = 3; exp_w = 1;
`endif
        @(negedge clk); start = 1'b1; cfg_num_cols = 16'(n_bad);
        @(negedge clk); start = 1'b0;
        checks++;
        if ({cfg_err, busy, in_ready} !== 3'b100) begin
            failures++; $display("FAIL illegal_pulse got=%b exp=100", {cfg_err, busy, in_ready});
        end
        @(negedge clk);
        checks++;
        if ({cfg_err, busy, in_ready} !== 3'b000) begin
            failures++; $display("FAIL illegal_after got=%b exp=000", {cfg_err, busy, in_ready});
        end
        run_stripe(n_min, 1'b0, 20, 1'b0);
        checks++;
        if (timed_out || win_cyc.size() != exp_w || res_cyc.size() != exp_w) begin
            failures++; $display("FAIL min_n_count got=win%0d res%0d exp=%0d", win_cyc.size(), res_cyc.size(), exp_w);
        end
        if (win_cyc.size() > 0) begin
            checks++;
`ifdef FPU_WIN_EDGE_REPLICATE_EN
            if (w0[0] != 21 || w1[0] != 21 || w2[0] != 22) begin
                failures++; $display("FAIL min_n_window got={%0d,%0d,%0d} exp={21,21,22}", w0[0], w1[0], w2[0]);
            end
`else
            if (w0[0] != 21 || w1[0] != 22 || w2[0] != 23) begin
                failures++; $display("FAIL min_n_window got={%0d,%0d,%0d} exp={21,22,23}", w0[0], w1[0], w2[0]);
            end
`endif
        end
        if (res_lst.size() > 0) begin
            checks++;
            if (res_lst[res_lst.size()-1] !== 1'b1) begin
                failures++; $display("FAIL min_n_last got=%0d exp=1", res_lst[res_lst.size()-1]);
            end
        end
    endtask

    task automatic test_start_busy;
        int bcnt, exp_w;
`ifdef FPU_WIN_EDGE_REPLICATE_EN
        exp_w = 9;
`else
        exp_w = 7;
`endif
        run_stripe(9, 1'b0, 0, 1'b1);
        checks++;
        if (timed_out || win_cyc.size() != exp_w || res_cyc.size() != exp_w) begin
            failures++; $display("FAIL busy_start_count got=win%0d res%0d exp=%0d", win_cyc.size(), res_cyc.size(), exp_w);
        end
        bcnt = 0;
        repeat (3) begin @(negedge clk); if (busy) bcnt++; end
        checks++;
        if (bcnt != 0) begin failures++; $display("FAIL busy_start_ignored got=%0d busy_cycles exp=0", bcnt); end
        run_stripe(4, 1'b0, 100, 1'b0);
        checks++;
        if (timed_out || win_cyc.size() == 0) begin
            failures++; $display("FAIL next_stripe_windows got=%0d exp>0", win_cyc.size());
        end else begin
`ifdef FPU_WIN_EDGE_REPLICATE_EN
            if (w0[0] != 101 || w1[0] != 101 || w2[0] != 102) begin
                failures++; $display("FAIL next_stripe_first got={%0d,%0d,%0d} exp={101,101,102}", w0[0], w1[0], w2[0]);
            end
`else
            if (w0[0] != 101 || w1[0] != 102 || w2[0] != 103) begin
                failures++; $display("FAIL next_stripe_first got={%0d,%0d,%0d} exp={101,102,103}", w0[0], w1[0], w2[0]);
            end
`endif
        end
    endtask

`ifdef FPU_WIN_EDGE_REPLICATE_EN
    task automatic test_edge;
        int e0[3] = '{1, 1, 2};
        int e1[3] = '{1, 2, 3};
        int e2[3] = '{2, 3, 3};
        run_stripe(3, 1'b0, 0, 1'b0);
        checks++;
        if (timed_out || win_cyc.size() != 3 || res_cyc.size() != 3) begin
            failures++; $display("FAIL edge_count got=win%0d res%0d exp=3", win_cyc.size(), res_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (w0[i] != e0[i] || w1[i] != e1[i] || w2[i] != e2[i]) begin
                    failures++; $display("FAIL edge_window%0d got={%0d,%0d,%0d} exp={%0d,%0d,%0d}",
                                         i, w0[i], w1[i], w2[i], e0[i], e1[i], e2[i]);
                end
                checks++;
                if (res_cyc[i] - win_cyc[i] != LAT || res_lst[i] != (i == 2)) begin
                    failures++; $display("FAIL edge_res%0d got=lat%0d last%0d exp=lat%0d last%0d",
                                         i, res_cyc[i] - win_cyc[i], res_lst[i], LAT, (i == 2));
                end
            end
            checks++;
            if (ready_drop != win_cyc[1] || win_cyc[2] != win_cyc[1] + 1) begin
                failures++; $display("FAIL edge_pad_ready got=drop%0d w2_%0d exp=drop%0d w2_%0d",
                                     ready_drop, win_cyc[2], win_cyc[1], win_cyc[1] + 1);
            end
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < CW; i++) in_col[i] = '0;
        test_reset();
`ifdef FPU_WIN_EDGE_REPLICATE_EN
        test_edge();
`else
        test_basic();
        test_bubbles();
`endif
        test_illegal();
        test_start_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_col_window.md
Name: fpu_col_window

Overview:
- Upstream feeder for the FPU 3x3 MAC stage.
- Accepts one pixel column (COL_WIDTH pixels) per transfer over a valid/ready handshake and keeps a three-column sliding window (col0 oldest/left, col2 newest/right).
- Presents the window to the MAC.
- Generates window-valid and result-valid/last tags aligned to MAC output latency, so the downstream writer knows which MAC outputs are meaningful.

Parameters:
- COL_WIDTH, 10: pixels per column; must match the MAC.
- MAC_LAT, 5: clock edges from window registers changing to MAC result_pixels reflecting them.
- CNT_W, 16: width of the column counter and cfg_num_cols.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: pulse that begins a stripe. Sampled only in IDLE.
- cfg_num_cols, input, CNT_W: columns in the stripe (N). Latched on accepted start.
- in_valid, input, 1: in_col holds a valid column.
- in_ready, output, 1: block accepts a column this cycle.
- in_col, input, 8 x COL_WIDTH (unpacked [COL_WIDTH-1:0]): incoming column. Pixel 0 is the top row.
- col0 / col1 / col2, output, 8 x COL_WIDTH each: window columns to the MAC.
- win_valid, output, 1: window registers hold a new valid window this cycle.
- res_valid, output, 1: MAC result_pixels are valid this cycle (win_valid delayed MAC_LAT).
- res_last, output, 1: qualifies the final result of the stripe.
- busy, output, 1: state is not IDLE.
- cfg_err, output, 1: one-cycle pulse when start arrives with an illegal N.

Behaviour:
- Reset: all outputs and the window are cleared to 0. State is IDLE, counters are 0, and the delay line is flushed. Reset mid-stripe abandons the stripe with no res_valid afterwards.
- States: IDLE, FILL, STREAM, DRAIN.
- IDLE:
  - start with N >= 3: latch N, clear col_cnt, go to FILL.
  - start with N < 3: pulse cfg_err next cycle, stay in IDLE.
- Accepted transfer: in_valid && in_ready. On each transfer, col0 <= col1, col1 <= col2, col2 <= in_col, and col_cnt increments.
- in_ready is high in FILL and STREAM, low in IDLE and DRAIN. It is combinational from state only, never from in_valid.
- FILL: after the 2nd accepted column, go to STREAM.
- STREAM:
  - Each accepted column raises win_valid for exactly the following cycle (registered), with the new window visible the same cycle.
  - Gaps with in_valid low hold the window unchanged and keep win_valid low.
  - On accepting column N (col_cnt reaches N), go to DRAIN and tag that window last.
- Windows per stripe: N-2.
- DRAIN:
  - Wait until the last tag exits the delay line, then return to IDLE. busy drops the same cycle.
  - start during DRAIN is ignored.
- Delay line: MAC_LAT stages of {valid, last}. res_valid/res_last equal win_valid/last delayed MAC_LAT cycles, so res_valid rises exactly MAC_LAT edges after the edge that loaded the window.
- Window registers are never cleared between stripes; only the tags gate usage.
- Simultaneous events: start is ignored outside IDLE. The last column and in_valid in the same cycle behave as above. No back-pressure from the MAC, which is free-running.

Optional Feature:
FPU_WIN_EDGE_REPLICATE_EN
- Defined: edge replication padding, producing N windows per stripe, with legal N >= 2.
  - The first accepted column loads col0, col1 and col2 simultaneously.
  - The first window {c0,c0,c1} is emitted after the 2nd column, so FILL needs 2 columns.
  - After column N, the block enters an internal PAD state for one cycle: in_ready is low, and the window shifts with col2 held, giving {cN-2,cN-1,cN-1}. That window is tagged last.
  - Then the block enters DRAIN.
- Undefined: behaviour is exactly as above, with N >= 3 and N-2 windows.

Decomposition:
- Package fpu_pkg holds:
  - pixel_t (logic [7:0]).
  - The column_t typedef, parameterised through COL_WIDTH.
  - win_state_t enum {IDLE, FILL, STREAM, DRAIN, PAD}.
  - FPU_MAC_LAT = 5.
- One sub-module: fpu_tag_delay, a MAC_LAT-deep {valid,last} shift register with async reset.

Test Plan:
- Reset: assert rst_n=0 mid-STREAM with N=8 after 4 columns -> all outputs 0, in_ready=0, and no res_valid for 10 cycles after release.
- Basic stream: N=5, columns c_k with every pixel = k+1, in_valid held high -> three win_valid pulses with windows {1,2,3}, {2,3,4}, {3,4,5}. res_valid is asserted on exactly 3 cycles, first 5 edges after the first win_valid. res_last accompanies the 3rd. busy falls after the last res_valid.
- Bubbles: N=6, in_valid toggling 1,0,1,0 -> window held during gaps, exactly 4 win_valid pulses, with spacing of res_valid identical to win_valid.
- Illegal config: start with N=2 -> cfg_err pulse, in_ready stays 0, busy stays 0. start with N=3 -> exactly 1 window.
- Start while busy: assert start during DRAIN with N=9 -> ignored. The next stripe begins only from IDLE, and its first window contains only new-stripe columns.
- Edge mode (FPU_WIN_EDGE_REPLICATE_EN): N=3, columns 1,2,3 -> windows {1,1,2}, {1,2,3}, {2,3,3}. in_ready is low for the PAD cycle, and res_last accompanies the 3rd.
